// File: rtl/wb_pkg.sv
// Write-back arbiter shared types: the buffered write entry and the producer ids.
package wb_pkg;

    localparam int WB_N     = 16;         // data width, matches the register file
    localparam int WB_R     = 3;          // register address width
    localparam int WB_DEPTH = 2;          // FIFO entries
    localparam int WB_NREG  = 1 << WB_R;  // number of architectural registers

    typedef struct packed {
        logic [WB_R-1:0] addr;
        logic [WB_N-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries. Pointers carry one extra wrap
// bit so full and empty are distinguished without a separate counter.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wb_entry_t i_entry,
    input  logic      i_pop,
    output wb_entry_t o_entry,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    wb_entry_t   r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_entry   = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance; reset empties the FIFO and discards whatever it held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin between ALU and memory results, FIFO buffer,
// registered register-file write port and a per-register pending scoreboard.
// Optional feature macro: WB_R0_HARDWIRED_EN (r0 reads as a constant; writes
// to it are dropped and it never becomes pending).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int n     = WB_N,
    parameter int r     = WB_R,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [r-1:0]    alu_addr,
    input  logic [n-1:0]    alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [r-1:0]    mem_addr,
    input  logic [n-1:0]    mem_data,
    input  logic            iss_valid,
    input  logic [r-1:0]    iss_addr,
    input  logic [r-1:0]    ra1,
    input  logic [r-1:0]    ra2,
    output logic            stall,
    input  logic            hold,
    output logic            we3,
    output logic [r-1:0]    wa3,
    output logic [n-1:0]    wd3,
    output logic [2**r-1:0] pending
);

    localparam int NREG = 1 << r;

    wb_src_e      r_last;
    logic         r_we3;
    logic [r-1:0] r_wa3;
    logic [n-1:0] r_wd3;
    logic [NREG-1:0] r_pending;

    logic      w_full;
    logic      w_empty;
    logic      w_alu_ready;
    logic      w_mem_ready;
    logic      w_push_alu;
    logic      w_push_mem;
    logic      w_push;
    logic      w_pop;
    logic      w_drop;
    logic      w_stall;
    wb_entry_t w_push_entry;
    wb_entry_t w_head;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;

    // Handshake: a transfer happens on an edge where valid && ready. A port's
    // ready looks only at FIFO fullness, the other port's valid and the
    // round-robin flag, never at its own valid. When both offer, the port not
    // granted last wins; ready is taken from registered full, so a full FIFO
    // is not refilled on the edge it pops.
    assign w_alu_ready = !w_full && (!mem_valid || (r_last == SRC_MEM));
    assign w_mem_ready = !w_full && (!alu_valid || (r_last == SRC_ALU));
    assign w_push_alu  = alu_valid && w_alu_ready;
    assign w_push_mem  = mem_valid && w_mem_ready;
    assign w_push      = w_push_alu || w_push_mem;
    assign w_pop       = !w_empty && !hold;

    assign alu_ready = w_alu_ready;
    assign mem_ready = w_mem_ready;

    // Select the granted producer's payload for the FIFO write.
    always_comb begin
        w_push_entry.addr = alu_addr;
        w_push_entry.data = alu_data;
        if (w_push_mem) begin
            w_push_entry.addr = mem_addr;
            w_push_entry.data = mem_data;
        end
    end

`ifdef WB_R0_HARDWIRED_EN
    assign w_drop = (w_head.addr == '0);
`else
    assign w_drop = 1'b0;
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_entry (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Round-robin flag moves only when an entry is actually accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= SRC_MEM;
        end else if (w_push_alu) begin
            r_last <= SRC_ALU;
        end else if (w_push_mem) begin
            r_last <= SRC_MEM;
        end
    end

    // Register-file write port; address/data hold when no write retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else if (w_pop && !w_drop) begin
            r_we3 <= 1'b1;
            r_wa3 <= w_head.addr;
            r_wd3 <= w_head.data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign w_stall = iss_valid &&
                     (r_pending[ra1] || r_pending[ra2] || r_pending[iss_addr]);

    // Scoreboard set/clear masks; a set on the same bit as a clear wins.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (iss_valid && !w_stall) w_set_mask[iss_addr] = 1'b1;
        if (r_we3)                 w_clr_mask[r_wa3]    = 1'b1;
`ifdef WB_R0_HARDWIRED_EN
        w_set_mask[0] = 1'b0;
`endif
    end

    // Pending bits: set on issue, cleared when the matching write retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign stall   = w_stall;
    assign we3     = r_we3;
    assign wa3     = r_wa3;
    assign wd3     = r_wd3;
    assign pending = r_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus, expected writes queued at issue
// time and checked in order by a monitor on the register-file port.
module tb_wb_arbiter;

    localparam int N = 16;
    localparam int R = 3;
`ifdef WB_R0_HARDWIRED_EN
    localparam bit R0HW = 1'b1;
`else
    localparam bit R0HW = 1'b0;
`endif

    // ---------------- clock / reset / signals ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         alu_valid, mem_valid;
    logic         alu_ready, mem_ready;
    logic [R-1:0] alu_addr, mem_addr;
    logic [N-1:0] alu_data, mem_data;
    logic         iss_valid;
    logic [R-1:0] iss_addr, ra1, ra2;
    logic         stall;
    logic         hold;
    logic         we3;
    logic [R-1:0] wa3;
    logic [N-1:0] wd3;
    logic [7:0]   pending;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .ra1       (ra1),
        .ra2       (ra2),
        .stall     (stall),
        .hold      (hold),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .pending   (pending)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [R+N-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_write(input logic [R-1:0] a, input logic [N-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [R+N-1:0] e;
        if (!rst && we3) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got wa3=%0d wd3=%h, required no write", wa3, wd3);
            end else begin
                e = exp_q.pop_front();
                if ({wa3, wd3} !== e) begin
                    n_err++;
                    $display("FAIL wb_order: got wa3=%0d wd3=%h, required wa3=%0d wd3=%h",
                             wa3, wd3, e[R+N-1:N], e[N-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int ai;
        int mi;
        rst = 1'b1;
        alu_valid = 0; mem_valid = 0;
        alu_addr = '0; mem_addr = '0; alu_data = '0; mem_data = '0;
        iss_valid = 0; iss_addr = '0; ra1 = '0; ra2 = '0; hold = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_we3", 32'(we3), 0);
        check("rst_wa3", 32'(wa3), 0);
        check("rst_wd3", 32'(wd3), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_alu_ready", 32'(alu_ready), 1);
        check("rst_mem_ready", 32'(mem_ready), 1);
        alu_valid = 1; mem_valid = 1;
        #1;
        check("tie_alu_first", 32'(alu_ready), 1);
        check("tie_mem_waits", 32'(mem_ready), 0);
        alu_valid = 0; mem_valid = 0;
        tick();

        // Single write to r3
        iss_valid = 1; iss_addr = 3; ra1 = 0; ra2 = 0;
        #1;
        check("single_stall", 32'(stall), 0);
        tick();
        iss_valid = 0;
        check("single_pend_set", 32'(pending), 32'h08);
        alu_valid = 1; alu_addr = 3; alu_data = 16'hBEEF;
        expect_write(3, 16'hBEEF);
        tick();                               // edge k
        alu_valid = 0;
        check("single_we3_k", 32'(we3), 0);
        tick();                               // edge k+1
        check("single_we3_k1", 32'(we3), 1);
        check("single_pend_k1", 32'(pending), 32'h08);
        tick();                               // edge k+2
        check("single_pend_k2", 32'(pending), 0);
        check("single_we3_k2", 32'(we3), 0);

        // Contention: last grant was ALU, so MEM wins the first tie
        ai = 0; mi = 0;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_addr = 1; alu_data = 16'hA000 + 16'(ai);
            mem_valid = 1; mem_addr = 2; mem_data = 16'hB000 + 16'(mi);
            #1;
            check("cont_alu_ready", 32'(alu_ready), (i % 2 == 1) ? 1 : 0);
            check("cont_mem_ready", 32'(mem_ready), (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) expect_write(2, 16'hB000 + 16'(mi));
            else            expect_write(1, 16'hA000 + 16'(ai));
            tick();
            if (i % 2 == 0) mi++;
            else            ai++;
            if (i > 0) check("cont_we3_busy", 32'(we3), 1);
        end
        alu_valid = 0; mem_valid = 0;
        tick();
        check("cont_we3_tail", 32'(we3), 1);
        tick();
        check("cont_we3_idle", 32'(we3), 0);

        // Backpressure under hold
        hold = 1;
        alu_valid = 1; alu_addr = 4; alu_data = 16'hC001;
        #1 check("bp_ready_1", 32'(alu_ready), 1);
        expect_write(4, 16'hC001);
        tick();
        alu_data = 16'hC002;
        #1 check("bp_ready_2", 32'(alu_ready), 1);
        expect_write(4, 16'hC002);
        tick();
        alu_data = 16'hC003;
        #1;
        check("bp_full_alu", 32'(alu_ready), 0);
        check("bp_full_mem", 32'(mem_ready), 0);
        tick();
        check("bp_still_full", 32'(alu_ready), 0);
        check("bp_held_we3", 32'(we3), 0);
        hold = 0;
        tick();                               // first pop; full clears
        check("bp_release_ready", 32'(alu_ready), 1);
        expect_write(4, 16'hC003);
        tick();
        alu_valid = 0;
        repeat (3) tick();

        // Hazards on r5
        iss_valid = 1; iss_addr = 5; ra1 = 0; ra2 = 0;
        #1 check("haz_first_issue", 32'(stall), 0);
        tick();
        iss_addr = 6; ra1 = 5;
        #1 check("haz_raw_stall", 32'(stall), 1);
        tick();
        check("haz_no_set", 32'(pending), 32'h20);
        iss_addr = 5; ra1 = 0;
        #1 check("haz_waw_stall", 32'(stall), 1);
        iss_valid = 0;
        mem_valid = 1; mem_addr = 5; mem_data = 16'hD005;
        expect_write(5, 16'hD005);
        tick();                               // edge k
        mem_valid = 0;
        tick();                               // edge k+1
        check("haz_pend_k1", 32'(pending), 32'h20);
        tick();                               // edge k+2
        check("haz_pend_clr", 32'(pending), 0);
        iss_valid = 1; iss_addr = 5; ra1 = 5;
        #1 check("haz_reissue_stall", 32'(stall), 0);
        tick();
        iss_valid = 0; ra1 = 0;
        check("haz_reset_bit", 32'(pending), 32'h20);

        // r0 handling
        iss_valid = 1; iss_addr = 0;
        tick();
        iss_valid = 0;
        check("r0_pend_issue", 32'(pending[0]), R0HW ? 0 : 1);
        alu_valid = 1; alu_addr = 0; alu_data = 16'h0123;
        if (!R0HW) expect_write(0, 16'h0123);
        tick();                               // edge k
        alu_valid = 0;
        tick();                               // edge k+1
        check("r0_we3", 32'(we3), R0HW ? 0 : 1);
        tick();
        check("r0_pend_after", 32'(pending[0]), 0);

        // Reset in the middle of buffered traffic
        hold = 1;
        alu_valid = 1; alu_addr = 7; alu_data = 16'hE001;
        tick();
        alu_data = 16'hE002;
        tick();
        alu_valid = 0;
        rst = 1;
        #1;
        check("mid_rst_we3", 32'(we3), 0);
        check("mid_rst_pending", 32'(pending), 0);
        tick();
        rst = 0; hold = 0;
        check("mid_rst_ready", 32'(alu_ready), 1);
        repeat (3) begin
            tick();
            check("mid_rst_no_write", 32'(we3), 0);
        end

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the gigaHurt datapath. It sits directly upstream of the register file's write port (`we3`/`wa3`/`wd3`). It accepts results from two producers, the single-cycle ALU and the multi-cycle memory/load path, through valid/ready handshakes, and buffers them in a small FIFO. It retires one write per cycle into the register file and keeps a per-register pending scoreboard that decode uses to stall on read-after-write and write-after-write hazards.

## Interface
- `n`, 16: data width, matching the register file.
- `r`, 3: register address width (2**r registers).
- `DEPTH`, 2: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  ALU result accepted this edge if `alu_valid`.
- `alu_addr`  in  r  destination register.
- `alu_data`  in  n  result.
- `mem_valid`, `mem_ready`, `mem_addr`, `mem_data`: same roles and widths for the memory path.
- `iss_valid`  in  1  decode wants to issue an instruction writing `iss_addr`.
- `iss_addr`  in  r  destination of the issuing instruction.
- `ra1`, `ra2`  in  r  source registers of the issuing instruction.
- `stall`  out  1  combinational hazard flag to decode.
- `hold`  in  1  freeze draining (pipeline freeze).
- `we3`  out  1  register-file write enable (registered).
- `wa3`  out  r  register-file write address (registered).
- `wd3`  out  n  register-file write data (registered).
- `pending`  out  2**r  scoreboard bits.

## Operation
- **Arbitration:** round-robin with a `last` flag.
  - Both valid: grant the source not granted last.
  - One valid: grant that source.
  - `last` updates only on an accepted push.
- **Ready:** `x_ready = !full && grant==x`. Ready may depend on the other port's valid, never on its own.
- **Push:** at most one entry per edge, taking `{addr,data}` from the granted source.
- **Pop:** when `!empty && !hold`, the head loads into the output register with `we3=1`. Otherwise `we3` is 0 next cycle; `wa3`/`wd3` hold their last value.
- **Full and empty together:** push and pop may occur on the same edge. Ready is still computed from registered `full`, so there is no same-edge refill when full.
- **Scoreboard:**
  - `stall = iss_valid && (pending[ra1] | pending[ra2] | pending[iss_addr])`.
  - An edge with `iss_valid && !stall` sets `pending[iss_addr]`.
  - An edge with `we3==1` clears `pending[wa3]`.
  - Set and clear of the same bit on one edge cannot occur, because the set is stalled while the bit is pending. If it arises anyway, set wins.
- A producer write to a non-pending register is still performed; its pending bit stays 0.

## Timing
- **Reset values:** FIFO empty; `we3=0`, `wa3=0`, `wd3=0`; `pending=0`; `last`=MEM, so the ALU wins the first tie. `alu_ready`/`mem_ready` follow from an empty FIFO.
- **Reset mid-operation:** buffered entries and the output register are discarded; no write is issued.
- **Latency:** an entry accepted at edge k with an empty FIFO and `hold=0` appears as `we3=1` from edge k+1. The register file writes at edge k+2, and `pending` clears at edge k+2.
- **Throughput:** one write per cycle sustained. With DEPTH=2, both producers alternate without bubbles once the FIFO holds an entry.
- **`hold`:** sampled every edge. A FIFO that is full under `hold` deasserts both readies until draining resumes.

## Configuration
- `WB_R0_HARDWIRED_EN` defined:
  - Entries addressed to r0 are accepted normally but dropped at pop; `we3` stays 0 that cycle and the entry is consumed.
  - Issue to r0 never sets `pending[0]`.
  - `pending[0]` is constant 0, so r0 never causes `stall`.
- `WB_R0_HARDWIRED_EN` undefined: r0 is an ordinary register in all paths.

## Structure
- Package `wb_pkg`:
  - `wb_entry_t` packed struct `{addr, data}`, parameterised via localparams matching `n`/`r`.
  - `wb_src_e` enum `{SRC_ALU, SRC_MEM}`.
- Sub-module `wb_fifo`: synchronous FIFO of `wb_entry_t`, DEPTH entries, with push/pop, `full`/`empty`, wrap-around pointers plus an extra bit, and async reset to empty.

## Test plan
- **Reset:** `rst` pulsed during traffic → next cycle `we3=0`, `pending=0`, FIFO empty; entries in flight never appear on `we3`.
- **Single write:** issue to r3 (sets `pending[3]`), then ALU pushes `{3,16'hBEEF}` at edge k → `we3=1`, `wa3=3`, `wd3=BEEF` in cycle k+1; `pending[3]` clears at k+2.
- **Contention:** both producers valid continuously with r1/r2 → grants alternate ALU, MEM, ALU…; `we3` high every cycle; no entry lost or duplicated.
- **Backpressure:** `hold=1` with 3 offers → 2 accepted, then both readies go low. Releasing `hold` drains in FIFO order.
- **Hazards:** `pending[5]=1`, `iss_valid=1` with `ra1=5` → `stall=1`. After the r5 write retires, `stall=0` and `iss_addr=5` re-sets the bit.
- **r0 (`WB_R0_HARDWIRED_EN`):** push to r0 → accepted, `we3` never asserted. Without the macro → `we3=1`, `wa3=0`.
